// File: rtl/sift_pkg.sv
// ============================================================================
// Module   : sift_pkg
// Brief    : Shared frame geometry, widths and sequencer state encoding for
//            the SIFT front-end frame controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_pkg;

    function automatic int flush_len(input int cols, input int rad);
        return rad * cols + rad;
    endfunction

    localparam int COLS      = 640;
    localparam int ROWS      = 480;
    localparam int MAX_RAD   = 3;
    localparam int PIPE_LAT  = 8;
    localparam int FLUSH_LEN = flush_len(COLS, MAX_RAD);

    localparam int COL_W    = 10;
    localparam int ROW_W    = 9;
    localparam int ROW_HEAD = 2;   // flush pushes the input row past the frame
    localparam int FLUSH_W  = 12;
    localparam int DRAIN_W  = 8;
    localparam int ROT_W    = 3;
    localparam int WIN_N    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sift_raster_cnt.sv
// ============================================================================
// Module   : sift_raster_cnt
// Brief    : Column/row raster counter with column wrap at COLS-1 and a
//            combinational row-wrap strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sift_raster_cnt #(
    parameter int COLS  = 640,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_row_wrap
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign o_row_wrap = i_en && (r_col == COL_W'(COLS - 1));
    assign o_col      = r_col;
    assign o_row      = r_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (o_row_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sift_frame_ctrl.sv
// ============================================================================
// Module   : sift_frame_ctrl
// Brief    : Raster-scan sequencer for the SIFT blur stack: issues pixel and
//            flush-pad steps, line-buffer addressing and window-centre flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sift_frame_ctrl #(
    parameter int COLS     = sift_pkg::COLS,
    parameter int ROWS     = sift_pkg::ROWS,
    parameter int MAX_RAD  = sift_pkg::MAX_RAD,
    parameter int PIPE_LAT = sift_pkg::PIPE_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       step,
    output logic       pad,
    output logic [9:0] lb_wr_addr,
    output logic [2:0] lb_rot,
    output logic [9:0] ctr_col,
    output logic [8:0] ctr_row,
    output logic       ctr_valid,
    output logic [2:0] win_inside,
    output logic       busy,
    output logic       frame_done,
    output logic       err_overrun
);
    import sift_pkg::*;

    localparam int c_flush_len = flush_len(COLS, MAX_RAD);
    localparam int c_in_row_w  = ROW_W + ROW_HEAD;
    localparam int c_rot_max   = 2 * MAX_RAD - 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [FLUSH_W-1:0]    r_flush_cnt;
    logic [FLUSH_W-1:0]    w_flush_nxt;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic [DRAIN_W-1:0]    w_drain_nxt;
    logic                  w_accept;
    logic                  w_pad;
    logic                  w_step;
    logic                  w_clear;
    logic                  w_last_px;

    logic [COL_W-1:0]      w_in_col;
    logic [c_in_row_w-1:0] w_in_row;
    logic                  w_in_wrap;
    logic [COL_W-1:0]      w_c_col;
    logic [ROW_W-1:0]      w_c_row;
    logic                  w_c_wrap_unused;
    logic                  w_ctr_valid;
    logic                  w_ctr_en;
    logic [WIN_N-1:0]      w_win;
    logic [ROT_W-1:0]      r_rot;

    logic                  r_step;
    logic                  r_pad;
    logic [COL_W-1:0]      r_lb_wr_addr;
    logic [ROT_W-1:0]      r_lb_rot;
    logic [COL_W-1:0]      r_ctr_col;
    logic [ROW_W-1:0]      r_ctr_row;
    logic                  r_ctr_valid;
    logic [WIN_N-1:0]      r_win_inside;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err_overrun;

    assign w_step    = w_accept | w_pad;
    assign w_last_px = (w_in_col == COL_W'(COLS - 1)) &&
                       (w_in_row == c_in_row_w'(ROWS - 1));

    // Centre index s - (MAX_RAD*COLS + MAX_RAD) >= 0 is the same as the input
    // position having reached (MAX_RAD, MAX_RAD) in raster order.
    assign w_ctr_valid = (w_in_row > c_in_row_w'(MAX_RAD)) ||
                         ((w_in_row == c_in_row_w'(MAX_RAD)) &&
                          (w_in_col >= COL_W'(MAX_RAD)));
    assign w_ctr_en    = w_step && w_ctr_valid;

    sift_raster_cnt #(
        .COLS  (COLS),
        .COL_W (COL_W),
        .ROW_W (c_in_row_w)
    ) u_in_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clear),
        .i_en       (w_step),
        .o_col      (w_in_col),
        .o_row      (w_in_row),
        .o_row_wrap (w_in_wrap)
    );

    sift_raster_cnt #(
        .COLS  (COLS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_ctr_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_clear),
        .i_en       (w_ctr_en),
        .o_col      (w_c_col),
        .o_row      (w_c_row),
        .o_row_wrap (w_c_wrap_unused)
    );

    for (genvar k = 1; k <= WIN_N; k++) begin : g_win
        assign w_win[k-1] = w_ctr_valid &&
                            (int'(w_c_col) >= k) && (int'(w_c_col) <= COLS - 1 - k) &&
                            (int'(w_c_row) >= k) && (int'(w_c_row) <= ROWS - 1 - k);
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_pad        = 1'b0;
        w_clear      = 1'b0;
        w_flush_nxt  = r_flush_cnt;
        w_drain_nxt  = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (w_last_px) begin
                        w_next_state = FLUSH;
                        w_flush_nxt  = FLUSH_W'(c_flush_len - 1);
                    end
                end
            end
            FLUSH: begin
                w_pad = 1'b1;
                if (r_flush_cnt == '0) begin
                    w_next_state = DRAIN;
                    w_drain_nxt  = DRAIN_W'(PIPE_LAT);
                end else begin
                    w_flush_nxt = r_flush_cnt - 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_next_state = IDLE;
                    w_clear      = 1'b1;
                end else begin
                    w_drain_nxt = r_drain_cnt - 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flush_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_flush_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Rotation is zero whenever IDLE is entered, so each frame starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot <= '0;
        end else if (w_clear) begin
            r_rot <= '0;
        end else if (w_in_wrap) begin
            r_rot <= (r_rot == ROT_W'(c_rot_max)) ? '0 : r_rot + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step        <= 1'b0;
            r_pad         <= 1'b0;
            r_lb_wr_addr  <= '0;
            r_lb_rot      <= '0;
            r_ctr_col     <= '0;
            r_ctr_row     <= '0;
            r_ctr_valid   <= 1'b0;
            r_win_inside  <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_step       <= w_step;
            r_pad        <= w_pad;
            r_busy       <= (w_next_state != IDLE);
            r_frame_done <= (w_next_state == DRAIN) && (w_drain_nxt == '0);
            if (r_state == IDLE && in_valid) begin
                r_err_overrun <= 1'b0;
            end else if (in_valid && (r_state == FLUSH || r_state == DRAIN)) begin
                r_err_overrun <= 1'b1;
            end
            if (w_step) begin
                r_lb_wr_addr <= w_in_col;
                r_lb_rot     <= r_rot;
                r_ctr_valid  <= w_ctr_valid;
                r_ctr_col    <= w_ctr_valid ? w_c_col : '0;
                r_ctr_row    <= w_ctr_valid ? w_c_row : '0;
                r_win_inside <= w_win;
            end
        end
    end

    assign step        = r_step;
    assign pad         = r_pad;
    assign lb_wr_addr  = r_lb_wr_addr;
    assign lb_rot      = r_lb_rot;
    assign ctr_col     = r_ctr_col;
    assign ctr_row     = r_ctr_row;
    assign ctr_valid   = r_ctr_valid;
    assign win_inside  = r_win_inside;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign err_overrun = r_err_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sift_frame_ctrl.sv
// ============================================================================
// Module   : tb_sift_frame_ctrl
// Brief    : Self-checking bench for sift_frame_ctrl on a small 8x6 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sift_frame_ctrl;

    localparam int COLS     = 8;
    localparam int ROWS     = 6;
    localparam int MAX_RAD  = 1;
    localparam int PIPE_LAT = 2;
    localparam int NPIX     = COLS * ROWS;
    localparam int LAG      = MAX_RAD * COLS + MAX_RAD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       step, pad, ctr_valid, busy, frame_done, err_overrun;
    logic [9:0] lb_wr_addr, ctr_col;
    logic [2:0] lb_rot, win_inside;
    logic [8:0] ctr_row;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sift_frame_ctrl #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .MAX_RAD  (MAX_RAD),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .step        (step),
        .pad         (pad),
        .lb_wr_addr  (lb_wr_addr),
        .lb_rot      (lb_rot),
        .ctr_col     (ctr_col),
        .ctr_row     (ctr_row),
        .ctr_valid   (ctr_valid),
        .win_inside  (win_inside),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_overrun (err_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is NPIX accepted pixels, LAG pad steps, then
    // PIPE_LAT idle cycles ending with frame_done.
    bit m_in_frame, m_err;
    int m_s, m_tail, e_s;
    bit e_step, e_pad, e_busy, e_done;

    initial begin : model
        m_in_frame = 0; m_err = 0; m_s = 0; m_tail = 0; e_s = 0;
        e_step = 0; e_pad = 0; e_busy = 0; e_done = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_in_frame = 0; m_err = 0; m_s = 0; m_tail = 0;
                e_step = 0; e_pad = 0; e_busy = 0; e_done = 0;
            end else begin
                e_step = 0; e_pad = 0; e_done = 0;
                if (!m_in_frame) begin
                    if (in_valid) begin
                        m_in_frame = 1; m_err = 0; m_tail = 0;
                        e_step = 1; e_s = 0; m_s = 1;
                    end
                end else if (m_s < NPIX) begin
                    if (in_valid) begin
                        e_step = 1; e_s = m_s; m_s++;
                    end
                end else if (m_s < NPIX + LAG) begin
                    e_step = 1; e_pad = 1; e_s = m_s; m_s++;
                    if (in_valid) m_err = 1;
                end else begin
                    if (in_valid) m_err = 1;
                    m_tail++;
                    if (m_tail == PIPE_LAT) e_done = 1;
                    if (m_tail > PIPE_LAT) m_in_frame = 0;
                end
                e_busy = m_in_frame;
            end
        end
    end

    initial begin : compare
        int c, ccol, crow;
        logic [2:0] w;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("step", step, e_step);
                check("pad", pad, e_pad);
                check("busy", busy, e_busy);
                check("frame_done", frame_done, e_done);
                check("err_overrun", err_overrun, m_err);
                if (e_step) begin
                    c    = e_s - LAG;
                    ccol = (c >= 0) ? c % COLS : 0;
                    crow = (c >= 0) ? c / COLS : 0;
                    for (int k = 1; k <= 3; k++)
                        w[k-1] = (c >= 0) && ccol >= k && ccol <= COLS - 1 - k &&
                                 crow >= k && crow <= ROWS - 1 - k;
                    check("lb_wr_addr", lb_wr_addr, e_s % COLS);
                    check("lb_rot", lb_rot, (e_s / COLS) % (2 * MAX_RAD));
                    check("ctr_valid", ctr_valid, c >= 0);
                    check("ctr_col", ctr_col, ccol);
                    check("ctr_row", ctr_row, crow);
                    check("win_inside", win_inside, w);
                end
            end
        end
    end

    // Observed-output statistics for hand-computed expectations.
    int cyc = 0, st_steps = 0, st_pad = 0, st_done = 0;
    int last_step_cyc = 0, done_cyc = 0, fv_idx = -1, fv_col = -1, fv_row = -1;
    int fr_steps[4], fr_pad[4], err_first[4], err_done[4];
    int cap_addr[3], cap_rot[3], cap_col[3], cap_row[3], cap_win[3], cap_pad[3];

    initial begin : stats
        int ci;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                st_steps = 0; st_pad = 0;
            end else begin
                if (step) begin
                    if (st_steps == 0 && st_done < 4) err_first[st_done] = err_overrun;
                    if (pad) st_pad++;
                    if (ctr_valid && fv_idx < 0) begin
                        fv_idx = st_steps; fv_col = ctr_col; fv_row = ctr_row;
                    end
                    ci = (st_steps == 27) ? 0 : (st_steps == 47) ? 1 : (st_steps == 56) ? 2 : -1;
                    if (ci >= 0) begin
                        cap_addr[ci] = lb_wr_addr; cap_rot[ci] = lb_rot;
                        cap_col[ci] = ctr_col; cap_row[ci] = ctr_row;
                        cap_win[ci] = win_inside; cap_pad[ci] = pad;
                    end
                    last_step_cyc = cyc;
                    st_steps++;
                end
                if (frame_done) begin
                    if (st_done < 4) begin
                        fr_steps[st_done] = st_steps; fr_pad[st_done] = st_pad;
                        err_done[st_done] = err_overrun;
                    end
                    st_done++; st_steps = 0; st_pad = 0; done_cyc = cyc;
                end
            end
        end
    end

    task automatic clear_stats();
        @(posedge clk);
        st_steps = 0; st_pad = 0; st_done = 0; fv_idx = -1; fv_col = -1; fv_row = -1;
        for (int i = 0; i < 4; i++) begin
            fr_steps[i] = -1; fr_pad[i] = -1; err_first[i] = -1; err_done[i] = -1;
        end
        for (int i = 0; i < 3; i++) begin
            cap_addr[i] = -1; cap_rot[i] = -1; cap_col[i] = -1;
            cap_row[i] = -1; cap_win[i] = -1; cap_pad[i] = -1;
        end
    endtask

    task automatic drive(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_valid = 1'b1;
            if (toggle) begin
                @(negedge clk); in_valid = 1'b0;
            end
        end
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int target);
        int n = 0;
        while (st_done < target && n < budget) begin
            @(posedge clk); n++;
        end
        check("done_within_budget", st_done >= target, 1);
    endtask

    task automatic check_caps();
        check("s27_addr", cap_addr[0], 3);  check("s27_rot", cap_rot[0], 1);
        check("s27_ccol", cap_col[0], 2);   check("s27_crow", cap_row[0], 2);
        check("s27_win", cap_win[0], 3);
        check("s47_addr", cap_addr[1], 7);  check("s47_rot", cap_rot[1], 1);
        check("s47_ccol", cap_col[1], 6);   check("s47_crow", cap_row[1], 4);
        check("s47_win", cap_win[1], 1);
        check("s56_addr", cap_addr[2], 0);  check("s56_rot", cap_rot[2], 1);
        check("s56_ccol", cap_col[2], 7);   check("s56_crow", cap_row[2], 5);
        check("s56_win", cap_win[2], 0);    check("s56_pad", cap_pad[2], 1);
    endtask

    initial begin : main
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err_overrun, 0);
        check("rst_addr", lb_wr_addr, 0);
        check("rst_ctr_valid", ctr_valid, 0);
        #2 rst_n = 1'b1;

        // Back-to-back frame
        clear_stats();
        drive(NPIX, 1'b0);
        wait_done(200, 1);
        check("b2b_steps", fr_steps[0], 57);
        check("b2b_pads", fr_pad[0], 9);
        check("b2b_done_lat", done_cyc - last_step_cyc, 2);
        check("b2b_first_valid", fv_idx, 9);
        check("b2b_first_ccol", fv_col, 0);
        check("b2b_first_crow", fv_row, 0);
        check_caps();
        repeat (4) @(negedge clk);
        check("b2b_done_count", st_done, 1);

        // Alternating in_valid
        clear_stats();
        drive(NPIX, 1'b1);
        wait_done(300, 1);
        check("tog_steps", fr_steps[0], 57);
        check("tog_pads", fr_pad[0], 9);
        check_caps();

        // in_valid held high across two frames
        clear_stats();
        @(negedge clk); in_valid = 1'b1;
        wait_done(400, 2);
        @(negedge clk); in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("ovr_steps_f0", fr_steps[0], 57);
        check("ovr_steps_f1", fr_steps[1], 57);
        check("ovr_err_done_f0", err_done[0], 1);
        check("ovr_err_done_f1", err_done[1], 1);
        check("ovr_err_first_f1", err_first[1], 0);
        check("ovr_done_count", st_done, 2);
        check("ovr_idle_busy", busy, 0);

        // Reset in the middle of a frame
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0;
        check("pre_rst_addr", lb_wr_addr, 3);
        check("pre_rst_ccol", ctr_col, 2);
        check("pre_rst_crow", ctr_row, 1);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", lb_wr_addr, 0);
        check("async_rst_ccol", ctr_col, 0);
        check("async_rst_valid", ctr_valid, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(NPIX, 1'b0);
        wait_done(200, 1);
        check("rst_frame_steps", fr_steps[0], 57);
        check("rst_frame_done_count", st_done, 1);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
